xcalc_engine: RTL and testbench
===============================

# xcalc_engine

Parametrised signed-integer calculator engine for the keypad calculator path. It sits between the key-code decoder and the display formatter. It accepts one decimal key code per handshake and assembles two signed operands of up to DIGITS digits. It executes add, subtract, multiply or divide (multi-cycle restoring divider) and presents a saturated two's-complement result with error flags; results can be chained into the next operation.

## Interface
- W, 11, result/operand width in bits, two's complement
- DIGITS, 3, max digits per operand; must satisfy 10^DIGITS-1 <= 2^(W-1)-1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear, priority over keys
- key_valid  in  1  key_code is valid
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 ignored
- key_ready  out  1  engine can accept a key
- result  out  W  signed result
- result_valid  out  1  result is current
- busy  out  1  execution in progress
- err_div0  out  1  last operation divided by zero
- err_ovf  out  1  last operation saturated

## Operation
- A key is accepted on a rising edge with key_valid && key_ready. key_ready = !busy.
- States: SIGN1, DIG1, OP, SIGN2, DIG2, EXEC, DONE. Reset or clear goes to SIGN1 with all registers zero.
- SIGN1: 10/11 set sign1 (+/-); the last sign key wins. A digit loads op1 = d and goes to DIG1. 12-14 are ignored.
- DIG1: a digit gives op1 = op1*10+d while the digit count < DIGITS. Extra digits are ignored. 10-13 latch the operator and go to SIGN2. 14 is ignored.
- SIGN2: 10/11 set sign2; the last wins. A digit loads op2 and goes to DIG2. 12-14 are ignored.
- DIG2: digits accumulate as in DIG1. 14 goes to EXEC. 10-13 are ignored.
- EXEC covers the signed operation a = ±op1 and b = ±op2:
  - add/sub/mul: computed in one cycle at width 2W internally.
  - div: restoring division on magnitudes, one quotient bit per cycle, W iterations. The quotient truncates toward zero. The sign is sign1 XOR sign2, and a zero quotient is always +0.
  - b == 0 with '/': result = 0, err_div0 = 1, no iteration.
- Saturation: a true result > 2^(W-1)-1 gives result = 2^(W-1)-1; a result < -2^(W-1) gives result = -2^(W-1). Either case sets err_ovf = 1.
- DONE: result_valid = 1. The result, result_valid and flags hold.
  - An operator key (10-13) chains: op1 takes the result as magnitude and sign1 takes its sign. The operator is latched and the state goes to SIGN2.
  - A digit starts a new calculation: state DIG1, op1 = d, sign1 = +.
  - 14 and 15 are ignored.
- result_valid, err_div0 and err_ovf clear on the first accepted key after DONE, or on clear. result keeps its value until overwritten.
- Key 15 is accepted and has no effect in any state.
- The operator is not cleared by sign keys; only a new operator key or clear changes it.

## Timing
- Reset values: result = 0, result_valid = 0, busy = 0, err_div0 = 0, err_ovf = 0, key_ready = 1. State is SIGN1.
- Latency is counted from the edge that accepts '=' (edge 0):
  - add/sub/mul and divide-by-zero: EXEC for 1 cycle; result and result_valid update at edge 2.
  - divide: 1 setup cycle plus W iteration cycles; result_valid rises at edge W+2.
- busy is high exactly during EXEC cycles. key_ready is low then, so keys are stalled, not dropped.
- clear asserted during EXEC aborts the division. At the next edge the state is SIGN1, all outputs are at reset values, and busy = 0.
- rst asserted at any time forces reset values immediately.
- clear and key_valid in the same cycle: clear wins and the key is not consumed.
- Flags update in the same edge as result.

## Test plan
- Keys 1,2,'+',3,4,'=' -> result = 46, result_valid at edge 2 after '=', no flags.
- Keys '-',5,'*',7,'=' -> result = -35 (0x7DD for W=11).
- Keys '-',1,0,0,'/',7,'=' -> result = -14; busy high for 12 cycles; result_valid at edge 13 (W=11).
- Keys 5,'/',0,'=' -> result = 0, err_div0 = 1, latency 2. The next key '1' clears err_div0 and starts DIG1.
- Keys 9,9,9,'*',9,9,9,'=' -> result = 1023, err_ovf = 1. Then '-',1,'=' (chain) -> result = 1022, err_ovf = 0.
- Start a divide, assert clear at the 4th EXEC cycle -> next edge: busy = 0, result_valid = 0, result = 0. Hold key_valid through EXEC and check it is accepted only after busy falls. rst low mid-entry -> immediate reset values.

Source files
------------

// File: rtl/xcalc_engine_if.sv
// Key-entry and result bus between the key-code decoder and the calculator engine.
// The master drives keys and clear; the slave (engine) returns the result and status.
interface xcalc_engine_if #(
  parameter int unsigned W = 11
) ();
  logic         clear;
  logic         key_valid;
  logic [3:0]   key_code;
  logic         key_ready;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         err_div0;
  logic         err_ovf;

  modport master (
    output clear, key_valid, key_code,
    input  key_ready, result, result_valid, busy, err_div0, err_ovf
  );

  modport slave (
    input  clear, key_valid, key_code,
    output key_ready, result, result_valid, busy, err_div0, err_ovf
  );
endinterface

// File: rtl/xcalc_engine.sv
// Signed keypad calculator engine: builds two operands from decimal keys, runs add/sub/mul in
// one cycle or a restoring divider over W cycles, then saturates and publishes the result.
module xcalc_engine #(
  parameter int unsigned W      = 11,
  parameter int unsigned DIGITS = 3
) (
  input logic           i_clk,
  input logic           i_rst_n,
  xcalc_engine_if.slave io_calc
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned IW = $clog2(W + 1);
  localparam int unsigned WW = 2 * W + 2;

  localparam logic [3:0] KeyAdd = 4'd10;
  localparam logic [3:0] KeySub = 4'd11;
  localparam logic [3:0] KeyDiv = 4'd13;
  localparam logic [3:0] KeyEq  = 4'd14;
  localparam logic [3:0] KeyNop = 4'd15;

  localparam logic signed [WW-1:0] MaxVal = WW'({(W-1){1'b1}});
  localparam logic signed [WW-1:0] MinVal = -MaxVal - WW'(1);

  typedef enum logic [2:0] {StSign1, StDig1, StSign2, StDig2, StExec, StDone} state_e;

  state_e               r_state;
  logic                 r_sign1, r_sign2;
  logic [W-1:0]         r_op1, r_op2;
  logic [CW-1:0]        r_cnt1, r_cnt2;
  logic [3:0]           r_opr;
  logic [W-1:0]         r_result;
  logic                 r_valid, r_div0, r_ovf;
  logic signed [WW-1:0] r_wide;
  logic                 r_fin, r_fin_div0;
  logic                 r_div_run, r_neg;
  logic [W-1:0]         r_rem, r_quo, r_dvs;
  logic [IW-1:0]        r_iter;

  logic                 w_acc, w_digit, w_oper;
  logic [3:0]           w_key;
  logic [W-1:0]         w_d;
  logic signed [WW-1:0] w_a, w_b, w_arith, w_quo_wide;
  logic [W:0]           w_rem_sh;
  logic                 w_qbit;
  logic [W-1:0]         w_rem_nxt, w_quo_nxt;
  logic [W-1:0]         w_sat, w_chain, w_chain_mag;
  logic                 w_sat_ovf;

  assign w_key   = io_calc.key_code;
  assign w_acc   = io_calc.key_valid && (r_state != StExec) && !io_calc.clear;
  assign w_digit = (w_key <= 4'd9);
  assign w_oper  = (w_key >= KeyAdd) && (w_key <= KeyDiv);
  assign w_d     = W'(w_key);

  always_comb begin
    w_a = $signed(WW'(r_op1));
    if (r_sign1) w_a = -w_a;
    w_b = $signed(WW'(r_op2));
    if (r_sign2) w_b = -w_b;
    case (r_opr)
      KeyAdd:  w_arith = w_a + w_b;
      KeySub:  w_arith = w_a - w_b;
      default: w_arith = w_a * w_b;
    endcase
  end

  // One restoring step: shift the next dividend bit into the remainder and try the subtract.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[W-1]};
    w_qbit    = (w_rem_sh >= {1'b0, r_dvs});
    w_rem_nxt = w_qbit ? (w_rem_sh[W-1:0] - r_dvs) : w_rem_sh[W-1:0];
    w_quo_nxt = {r_quo[W-2:0], w_qbit};
    w_quo_wide = $signed(WW'(w_quo_nxt));
    if (r_neg) w_quo_wide = -w_quo_wide;
  end

  always_comb begin
    w_sat     = r_wide[W-1:0];
    w_sat_ovf = 1'b0;
    if (r_wide > MaxVal) begin
      w_sat     = MaxVal[W-1:0];
      w_sat_ovf = 1'b1;
    end else if (r_wide < MinVal) begin
      w_sat     = MinVal[W-1:0];
      w_sat_ovf = 1'b1;
    end
    // A chaining key may land on the same edge the finished result is published.
    w_chain     = r_fin ? w_sat : r_result;
    w_chain_mag = w_chain[W-1] ? (-w_chain) : w_chain;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StSign1;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_cnt1     <= '0;
      r_cnt2     <= '0;
      r_opr      <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wide     <= '0;
      r_fin      <= 1'b0;
      r_fin_div0 <= 1'b0;
      r_div_run  <= 1'b0;
      r_neg      <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_iter     <= '0;
    end else if (io_calc.clear) begin
      r_state    <= StSign1;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_cnt1     <= '0;
      r_cnt2     <= '0;
      r_opr      <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wide     <= '0;
      r_fin      <= 1'b0;
      r_fin_div0 <= 1'b0;
      r_div_run  <= 1'b0;
      r_neg      <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_iter     <= '0;
    end else begin
      r_fin <= 1'b0;
      if (r_fin) begin
        r_result <= w_sat;
        r_valid  <= 1'b1;
        r_div0   <= r_fin_div0;
        r_ovf    <= w_sat_ovf;
      end
      case (r_state)
        StSign1: if (w_acc) begin
          if (w_key == KeyAdd) r_sign1 <= 1'b0;
          else if (w_key == KeySub) r_sign1 <= 1'b1;
          else if (w_digit) begin
            r_op1   <= w_d;
            r_cnt1  <= CW'(1);
            r_state <= StDig1;
          end
        end
        StDig1: if (w_acc) begin
          if (w_digit) begin
            if (r_cnt1 < CW'(DIGITS)) begin
              r_op1  <= r_op1 * W'(10) + w_d;
              r_cnt1 <= r_cnt1 + CW'(1);
            end
          end else if (w_oper) begin
            r_opr   <= w_key;
            r_sign2 <= 1'b0;
            r_op2   <= '0;
            r_cnt2  <= '0;
            r_state <= StSign2;
          end
        end
        StSign2: if (w_acc) begin
          if (w_key == KeyAdd) r_sign2 <= 1'b0;
          else if (w_key == KeySub) r_sign2 <= 1'b1;
          else if (w_digit) begin
            r_op2   <= w_d;
            r_cnt2  <= CW'(1);
            r_state <= StDig2;
          end
        end
        StDig2: if (w_acc) begin
          if (w_digit) begin
            if (r_cnt2 < CW'(DIGITS)) begin
              r_op2  <= r_op2 * W'(10) + w_d;
              r_cnt2 <= r_cnt2 + CW'(1);
            end
          end else if (w_key == KeyEq) begin
            r_div_run <= 1'b0;
            r_state   <= StExec;
          end
        end
        StExec: begin
          if (!r_div_run) begin
            if (r_opr != KeyDiv) begin
              r_wide     <= w_arith;
              r_fin      <= 1'b1;
              r_fin_div0 <= 1'b0;
              r_state    <= StDone;
            end else if (r_op2 == '0) begin
              r_wide     <= '0;
              r_fin      <= 1'b1;
              r_fin_div0 <= 1'b1;
              r_state    <= StDone;
            end else begin
              r_div_run <= 1'b1;
              r_rem     <= '0;
              r_quo     <= r_op1;
              r_dvs     <= r_op2;
              r_neg     <= r_sign1 ^ r_sign2;
              r_iter    <= IW'(W);
            end
          end else begin
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_iter <= r_iter - IW'(1);
            if (r_iter == IW'(1)) begin
              r_wide     <= w_quo_wide;
              r_fin      <= 1'b1;
              r_fin_div0 <= 1'b0;
              r_div_run  <= 1'b0;
              r_state    <= StDone;
            end
          end
        end
        StDone: if (w_acc && (w_key != KeyNop)) begin
          r_valid <= 1'b0;
          r_div0  <= 1'b0;
          r_ovf   <= 1'b0;
          if (w_oper) begin
            r_op1   <= w_chain_mag;
            r_sign1 <= w_chain[W-1];
            r_opr   <= w_key;
            r_sign2 <= 1'b0;
            r_op2   <= '0;
            r_cnt2  <= '0;
            r_state <= StSign2;
          end else if (w_digit) begin
            r_op1   <= w_d;
            r_sign1 <= 1'b0;
            r_cnt1  <= CW'(1);
            r_state <= StDig1;
          end
        end
        default: r_state <= StSign1;
      endcase
    end
  end

  assign io_calc.key_ready    = (r_state != StExec);
  assign io_calc.busy         = (r_state == StExec);
  assign io_calc.result       = r_result;
  assign io_calc.result_valid = r_valid;
  assign io_calc.err_div0     = r_div0;
  assign io_calc.err_ovf      = r_ovf;

endmodule

// File: tb/tb_xcalc_engine.sv
// Directed bench for xcalc_engine: a table of key sequences with hand-computed results,
// then hand-written sequences for chaining, stalls, clear-abort and asynchronous reset.
module tb_xcalc_engine;

  localparam int unsigned W = 11;

  logic i_clk;
  logic i_rst_n;
  int   n_chk;
  int   n_err;

  xcalc_engine_if #(.W(W)) u_if ();

  xcalc_engine #(.W(W), .DIGITS(3)) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .io_calc (u_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [47:0] keys;    // one key per nibble, first key in the most significant used nibble
    int          n;
    int          exp_res;
    int          exp_div0;
    int          exp_ovf;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, got, got, exp, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    int n;
    @(negedge i_clk);
    u_if.key_valid = 1'b1;
    u_if.key_code  = k;
    n = 0;
    while (!u_if.key_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) check("press_stall_bound", n, 0);
    @(posedge i_clk);
    #1;
    u_if.key_valid = 1'b0;
  endtask

  task automatic press_seq(input logic [47:0] keys, input int n);
    logic [47:0] ks;
    ks = keys;
    for (int i = 0; i < n; i++) press(ks[4*(n-1-i) +: 4]);
  endtask

  task automatic do_clear();
    @(negedge i_clk);
    u_if.clear = 1'b1;
    @(posedge i_clk);
    #1;
    u_if.clear = 1'b0;
  endtask

  // Called just after the edge that accepted '='; returns the edge index of result_valid.
  task automatic wait_done(output int e, output int bc);
    bc = u_if.busy ? 1 : 0;
    e  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge i_clk);
      #1;
      if (u_if.busy) bc++;
      if (u_if.result_valid) begin
        e = i;
        break;
      end
    end
  endtask

  initial begin
    int e;
    int bc;
    int n;
    n_chk = 0;
    n_err = 0;

    // Key nibbles: A '+', B '-', C '*', D '/', E '=', F ignored.
    vecs[0] = '{"add_12_34",    48'h12A34E,     6, 46,    0, 0, 2};
    vecs[1] = '{"mul_m5_7",     48'hB5C7E,      5, 'h7DD, 0, 0, 2};
    vecs[2] = '{"div_m100_7",   48'hB100D7E,    7, 'h7F2, 0, 0, 13};
    vecs[3] = '{"div_by_zero",  48'h5D0E,       4, 0,     1, 0, 2};
    vecs[4] = '{"mul_pos_sat",  48'h999C999E,   8, 'h3FF, 0, 1, 2};
    vecs[5] = '{"extra_digits", 48'h1234A1E,    7, 124,   0, 0, 2};
    vecs[6] = '{"sign_keys",    48'hBA8BB3E,    7, 11,    0, 0, 2};
    vecs[7] = '{"ignored_keys", 48'hFC20EDFB6E, 10, 'h7FD, 0, 0, 13};
    vecs[8] = '{"div_zero_quo", 48'hB3DB5E,     6, 0,     0, 0, 13};
    vecs[9] = '{"mul_neg_sat",  48'hB999C2E,    7, 'h400, 0, 1, 2};

    i_rst_n        = 1'b0;
    u_if.clear     = 1'b0;
    u_if.key_valid = 1'b0;
    u_if.key_code  = 4'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_result", int'(u_if.result), 0);
    check("rst_valid", int'(u_if.result_valid), 0);
    check("rst_busy", int'(u_if.busy), 0);
    check("rst_ready", int'(u_if.key_ready), 1);
    check("rst_div0", int'(u_if.err_div0), 0);
    check("rst_ovf", int'(u_if.err_ovf), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      do_clear();
      press_seq(vecs[v].keys, vecs[v].n);
      wait_done(e, bc);
      check({vecs[v].name, "_latency"}, e, vecs[v].lat);
      check({vecs[v].name, "_busy_cycles"}, bc, vecs[v].lat - 1);
      check({vecs[v].name, "_result"}, int'(u_if.result), vecs[v].exp_res);
      check({vecs[v].name, "_div0"}, int'(u_if.err_div0), vecs[v].exp_div0);
      check({vecs[v].name, "_ovf"}, int'(u_if.err_ovf), vecs[v].exp_ovf);
    end

    // Divide by zero, then a digit starts a fresh calculation and drops the flag.
    do_clear();
    press_seq(48'h5D0E, 4);
    wait_done(e, bc);
    check("d0_flag", int'(u_if.err_div0), 1);
    press(4'd1);
    check("d0_flag_cleared", int'(u_if.err_div0), 0);
    check("d0_valid_cleared", int'(u_if.result_valid), 0);
    press_seq(48'hA2E, 3);
    wait_done(e, bc);
    check("d0_next_calc", int'(u_if.result), 3);

    // Saturated result chained into a subtraction.
    do_clear();
    press_seq(48'h999C999E, 8);
    wait_done(e, bc);
    check("chain_sat_ovf", int'(u_if.err_ovf), 1);
    press_seq(48'hB1E, 3);
    wait_done(e, bc);
    check("chain_result", int'(u_if.result), 1022);
    check("chain_ovf_cleared", int'(u_if.err_ovf), 0);

    // Operator key held through a divide: stalled while busy, then chains on the quotient.
    press_seq(48'h8D2E, 4);
    @(negedge i_clk);
    u_if.key_valid = 1'b1;
    u_if.key_code  = 4'hA;
    n = 0;
    while (!u_if.key_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    check("stall_cycles", n, 12);
    @(posedge i_clk);
    #1;
    u_if.key_valid = 1'b0;
    check("stall_quotient", int'(u_if.result), 4);
    check("stall_valid_after_key", int'(u_if.result_valid), 0);
    press_seq(48'h3E, 2);
    wait_done(e, bc);
    check("stall_chain_result", int'(u_if.result), 7);

    // Clear in the 4th EXEC cycle of a divide with a digit key held.
    press_seq(48'h9D2E, 4);
    @(negedge i_clk);
    u_if.key_valid = 1'b1;
    u_if.key_code  = 4'd7;
    @(posedge i_clk);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("abort_busy_before", int'(u_if.busy), 1);
    u_if.clear = 1'b1;
    @(posedge i_clk);
    #1;
    u_if.clear = 1'b0;
    check("abort_busy", int'(u_if.busy), 0);
    check("abort_valid", int'(u_if.result_valid), 0);
    check("abort_result", int'(u_if.result), 0);
    check("abort_ready", int'(u_if.key_ready), 1);
    @(posedge i_clk);
    #1;
    u_if.key_valid = 1'b0;
    press_seq(48'hA1E, 3);
    wait_done(e, bc);
    check("abort_key_once", int'(u_if.result), 8);

    // Asynchronous reset in the middle of operand entry.
    press_seq(48'h12, 2);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_result", int'(u_if.result), 0);
    check("arst_valid", int'(u_if.result_valid), 0);
    check("arst_ready", int'(u_if.key_ready), 1);
    check("arst_busy", int'(u_if.busy), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    press_seq(48'h3A4E, 4);
    wait_done(e, bc);
    check("arst_fresh_calc", int'(u_if.result), 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
